porta_z80_bus_master: RTL and testbench

PORTA_Z80_BUS_MASTER -- requirements
Module: porta_z80_bus_master

---
 rtl/porta_z80_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_porta_z80_bus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/porta_z80_bus_master.sv
// Z80 bus master: turns one command at a time into Z80 T-state bus cycles
// (memory, I/O, opcode fetch with refresh) and returns a one-clock response.
module porta_z80_bus_master #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        RESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        MREQn,
    output logic        IORQn,
    output logic        RDn,
    output logic        WRn,
    output logic        M1n,
    output logic        RFSHn,
    input  logic        WAITn
);
    localparam int WCW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4} state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [2:0]     type_reg;
    logic [15:0]    a_reg;
    logic [7:0]     d_out_reg;
    logic [7:0]     fetch_data_reg;
    logic [6:0]     r_reg;
    logic           run_reg;
    logic           rsp_valid_reg, rsp_err_reg, rsp_timeout_reg;
    logic [7:0]     rsp_rdata_reg;
    logic           timeout_now;

    wire accept    = cmd_valid && cmd_ready;
    wire reserved  = (cmd_type >= 3'd5);
    wire is_mrd    = (type_reg == 3'd0);
    wire is_mwr    = (type_reg == 3'd1);
    wire is_ird    = (type_reg == 3'd2);
    wire is_iwr    = (type_reg == 3'd3);
    wire is_fetch  = (type_reg == 3'd4);
    wire is_io     = is_ird || is_iwr;

    // Ready only once the first clean clock after reset release has passed.
    assign cmd_ready   = (state_reg == S_IDLE) && run_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign A           = a_reg;
    assign D_out       = d_out_reg;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_now   = 1'b0;
        MREQn = 1'b1; IORQn = 1'b1; RDn = 1'b1; WRn = 1'b1;
        M1n   = 1'b1; RFSHn = 1'b1; D_oe = 1'b0;

        case (state_reg)
            S_IDLE: if (accept && !reserved) state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2, S_TWA: begin
                if (state_reg == S_T2 && is_io) begin
                    state_next = S_TWA;
                end else if (WAITn) begin
                    state_next = S_T3;
                end else begin
                    state_next    = S_TW;
                    wait_cnt_next = WCW'(1);
                end
            end
            S_TW: begin
                if (WAITn) begin
                    state_next = S_T3;
                end else if (wait_cnt_reg >= WAIT_MAX) begin
                    state_next  = S_IDLE;
                    timeout_now = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_T3:    state_next = is_fetch ? S_T4 : S_IDLE;
            S_T4:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Access phase: T1 through the wait states, plus T3 of non-fetch cycles.
        if (state_reg == S_T1 || state_reg == S_T2 || state_reg == S_TWA ||
            state_reg == S_TW || (state_reg == S_T3 && !is_fetch)) begin
            if (is_mrd || is_fetch) begin
                MREQn = 1'b0;
                RDn   = 1'b0;
            end
            if (is_fetch) M1n = 1'b0;
            if (is_mwr) begin
                D_oe = 1'b1;
                if (state_reg != S_T1) begin
                    MREQn = 1'b0;
                    WRn   = 1'b0;
                end
            end
            if (is_ird && state_reg != S_T1) begin
                IORQn = 1'b0;
                RDn   = 1'b0;
            end
            if (is_iwr && state_reg != S_T1) begin
                IORQn = 1'b0;
                WRn   = 1'b0;
                D_oe  = 1'b1;
            end
        end
        if (state_reg == S_T3 && is_fetch) RFSHn = 1'b0;
        if (state_reg == S_T4) begin
            RFSHn = 1'b0;
            MREQn = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            type_reg        <= 3'd0;
            a_reg           <= 16'h0000;
            d_out_reg       <= 8'h00;
            fetch_data_reg  <= 8'h00;
            r_reg           <= 7'd0;
            run_reg         <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= 8'h00;
        end else begin
            run_reg         <= 1'b1;
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;

            if (accept) begin
                if (reserved) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b1;
                    rsp_rdata_reg <= 8'h00;
                end else begin
                    type_reg  <= cmd_type;
                    a_reg     <= cmd_addr;
                    d_out_reg <= cmd_wdata;
                end
            end

            // Opcode is taken before the bus switches to the refresh address.
            if (is_fetch && state_next == S_T3 && state_reg != S_T3) begin
                fetch_data_reg <= D_in;
                a_reg          <= {9'b0, r_reg};
            end

            if (state_reg == S_T3 && !is_fetch) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= (is_mrd || is_ird) ? D_in : 8'h00;
            end

            if (state_reg == S_T4) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= fetch_data_reg;
                r_reg         <= r_reg + 7'd1;
            end

            if (timeout_now) begin
                rsp_valid_reg   <= 1'b1;
                rsp_timeout_reg <= 1'b1;
                rsp_rdata_reg   <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_porta_z80_bus_master.sv
// Scoreboarded bench for porta_z80_bus_master: the driver queues expected
// responses and bus-activity totals, a negedge monitor tallies and compares.
module tb_porta_z80_bus_master;
    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_type = 3'd0;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in = 8'h0;
    logic        MREQn, IORQn, RDn, WRn, M1n, RFSHn;
    logic        WAITn = 1'b1;

    always #5 clk = ~clk;

    porta_z80_bus_master #(.WAIT_LIMIT(255)) dut (
        .clk(clk), .RESETn(RESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .MREQn(MREQn), .IORQn(IORQn), .RDn(RDn), .WRn(WRn), .M1n(M1n),
        .RFSHn(RFSHn), .WAITn(WAITn)
    );

    typedef struct {
        int          lat;
        logic [7:0]  rdata;
        logic        err;
        logic        tmo;
        int          n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_oe;
        logic        chk_a;
        logic [15:0] a1;
        logic        chk_rf;
        logic [15:0] arf;
        logic        chk_wd;
        logic [7:0]  wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [7:0] rdata, input logic err,
                                input logic tmo, input int mreq, input int iorq, input int rd,
                                input int wr, input int m1, input int rfsh, input int oe,
                                input logic chk_a, input logic [15:0] a1, input logic chk_rf,
                                input logic [15:0] arf, input logic chk_wd, input logic [7:0] wd);
        exp_t e;
        e.lat = lat; e.rdata = rdata; e.err = err; e.tmo = tmo;
        e.n_mreq = mreq; e.n_iorq = iorq; e.n_rd = rd; e.n_wr = wr;
        e.n_m1 = m1; e.n_rfsh = rfsh; e.n_oe = oe;
        e.chk_a = chk_a; e.a1 = a1; e.chk_rf = chk_rf; e.arf = arf;
        e.chk_wd = chk_wd; e.wd = wd;
        return e;
    endfunction

    // Monitor state
    bit          in_txn = 0;
    int          cyc, c_mreq, c_iorq, c_rd, c_wr, c_m1, c_rf, c_oe;
    logic [15:0] a_first, a_rf;
    logic [7:0]  wd_seen;
    exp_t        cur;

    always @(negedge clk) begin
        chk("mreq_iorq_exclusive", {31'b0, (!MREQn && !IORQn)}, 32'd0);
        chk("rd_wr_exclusive", {31'b0, (!RDn && !WRn)}, 32'd0);
        if (!RESETn) begin
            in_txn = 0;
        end else begin
            if (in_txn) begin
                cyc++;
                if (!MREQn) c_mreq++;
                if (!IORQn) c_iorq++;
                if (!RDn)   c_rd++;
                if (!WRn)   c_wr++;
                if (!M1n)   c_m1++;
                if (!RFSHn) begin c_rf++; a_rf = A; end
                if (D_oe)   begin c_oe++; wd_seen = D_out; end
                if (cyc == 1) a_first = A;
                if (rsp_valid) begin
                    in_txn = 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected: rsp_valid with no queued command");
                    end else begin
                        cur = exp_q.pop_front();
                        $display("txn: lat=%0d rdata=%02h err=%0b tmo=%0b A1=%04h",
                                 cyc, rsp_rdata, rsp_err, rsp_timeout, a_first);
                        chk("latency", cyc, cur.lat);
                        chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, cur.rdata});
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
                        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, cur.tmo});
                        chk("mreq_clks", c_mreq, cur.n_mreq);
                        chk("iorq_clks", c_iorq, cur.n_iorq);
                        chk("rd_clks", c_rd, cur.n_rd);
                        chk("wr_clks", c_wr, cur.n_wr);
                        chk("m1_clks", c_m1, cur.n_m1);
                        chk("rfsh_clks", c_rf, cur.n_rfsh);
                        chk("doe_clks", c_oe, cur.n_oe);
                        chk("idle_bus", {25'b0, MREQn, IORQn, RDn, WRn, M1n, RFSHn, D_oe},
                            32'b1111110);
                        if (cur.chk_a)  chk("addr_t1", {16'b0, a_first}, {16'b0, cur.a1});
                        if (cur.chk_rf) chk("addr_refresh", {16'b0, a_rf}, {16'b0, cur.arf});
                        if (cur.chk_wd) chk("d_out", {24'b0, wd_seen}, {24'b0, cur.wd});
                    end
                end else if (cyc > 400) begin
                    in_txn = 0;
                    checks++; errors++;
                    $display("FAIL rsp_missing: no rsp_valid within 400 clks of accept");
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                end
            end else if (rsp_valid) begin
                checks++; errors++;
                $display("FAIL rsp_spurious: rsp_valid=1 outside a command");
            end
            if (!in_txn && cmd_valid && cmd_ready) begin
                in_txn = 1;
                cyc = 0; c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0;
                c_m1 = 0; c_rf = 0; c_oe = 0;
                a_rf = 16'hxxxx; wd_seen = 8'hxx;
            end
        end
    end

    // Drives one command; waits are inserted from the first wait-sampled state.
    task automatic issue(input logic [2:0] t, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] din, input int nwait, input exp_t e);
        int n;
        cmd_type = t; cmd_addr = addr; cmd_wdata = wd; D_in = din; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
        exp_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (t <= 3'd4) begin
            repeat ((t == 3'd2 || t == 3'd3) ? 2 : 1) begin @(posedge clk); #1; end
            if (nwait > 0) begin
                WAITn = 1'b0;
                repeat (nwait) begin @(posedge clk); #1; end
                WAITn = 1'b1;
            end
            if (t == 3'd4 && !e.tmo) begin
                @(posedge clk); #1;
                D_in = ~din;
            end
        end
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 400) begin n++; @(negedge clk); end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("reset_strobes", {26'b0, MREQn, IORQn, RDn, WRn, M1n, RFSHn}, 32'b111111);
        chk("reset_doe", {31'b0, D_oe}, 32'd0);
        chk("reset_A", {16'b0, A}, 32'd0);
        chk("reset_dout", {24'b0, D_out}, 32'd0);
        chk("reset_rsp", {22'b0, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 32'd0);
        @(posedge clk); #1;
        RESETn = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_release", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        issue(3'd0, 16'h8000, 8'h00, 8'h5A, 0, mk(4, 8'h5A, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1, 16'h8000, 0, 0, 0, 0));
        issue(3'd1, 16'h1234, 8'hA5, 8'h00, 0, mk(4, 8'h00, 0, 0, 2, 0, 0, 2, 0, 0, 3, 1, 16'h1234, 0, 0, 1, 8'hA5));
        issue(3'd3, 16'h00BE, 8'h3C, 8'h00, 0, mk(5, 8'h00, 0, 0, 0, 3, 0, 3, 0, 0, 3, 1, 16'h00BE, 0, 0, 1, 8'h3C));
        issue(3'd2, 16'h0077, 8'h00, 8'hC3, 0, mk(5, 8'hC3, 0, 0, 0, 3, 3, 0, 0, 0, 0, 1, 16'h0077, 0, 0, 0, 0));
        issue(3'd2, 16'h0055, 8'h00, 8'h11, 1, mk(6, 8'h11, 0, 0, 0, 4, 4, 0, 0, 0, 0, 1, 16'h0055, 0, 0, 0, 0));
        issue(3'd0, 16'h4000, 8'h00, 8'h99, 3, mk(7, 8'h99, 0, 0, 6, 0, 6, 0, 0, 0, 0, 1, 16'h4000, 0, 0, 0, 0));
        issue(3'd1, 16'h9ABC, 8'h42, 8'h00, 2, mk(6, 8'h00, 0, 0, 4, 0, 0, 4, 0, 0, 5, 1, 16'h9ABC, 0, 0, 1, 8'h42));

        for (int i = 0; i < 130; i++) begin
            logic [7:0]  op;
            logic [15:0] rf;
            op = 8'(i * 3 + 1);
            rf = 16'(i % 128);
            issue(3'd4, 16'h0000, 8'h00, op, 0, mk(5, op, 0, 0, 3, 0, 2, 0, 2, 2, 0, 1, 16'h0000, 1, rf, 0, 0));
        end
        issue(3'd4, 16'h0100, 8'h00, 8'hE7, 2, mk(7, 8'hE7, 0, 0, 5, 0, 4, 0, 4, 2, 0, 1, 16'h0100, 1, 16'h0002, 0, 0));

        issue(3'd0, 16'h2222, 8'h00, 8'hFF, 256, mk(258, 8'h00, 0, 1, 257, 0, 257, 0, 0, 0, 0, 1, 16'h2222, 0, 0, 0, 0));
        issue(3'd4, 16'h0300, 8'h00, 8'h77, 256, mk(258, 8'h00, 0, 1, 257, 0, 257, 0, 257, 0, 0, 1, 16'h0300, 0, 0, 0, 0));
        issue(3'd4, 16'h0400, 8'h00, 8'h3D, 0, mk(5, 8'h3D, 0, 0, 3, 0, 2, 0, 2, 2, 0, 1, 16'h0400, 1, 16'h0003, 0, 0));

        issue(3'd5, 16'hFFFF, 8'h00, 8'h00, 0, mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(3'd7, 16'hFFFF, 8'h00, 8'h00, 0, mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset while a memory write sits in TW.
        cmd_type = 3'd1; cmd_addr = 16'h5555; cmd_wdata = 8'h99; cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        WAITn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("tw_write_strobes", {29'b0, MREQn, WRn, D_oe}, 32'b001);
        @(posedge clk); #1;
        RESETn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset_strobes", {26'b0, MREQn, IORQn, RDn, WRn, M1n, RFSHn}, 32'b111111);
        chk("midreset_doe", {31'b0, D_oe}, 32'd0);
        chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midreset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        WAITn = 1'b1;
        RESETn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        issue(3'd4, 16'h0500, 8'h00, 8'hAB, 0, mk(5, 8'hAB, 0, 0, 3, 0, 2, 0, 2, 2, 0, 1, 16'h0500, 1, 16'h0000, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
